cholesky_recon: RTL and testbench

- Inverse of the Cholesky factoriser: takes a packed 5x5 lower-triangular factor L and rebuilds the symmetric matrix A = L·Lᵀ, lower triangle only.
- Closes the loop in the sigma-point datapath: it self-checks factoriser output, and it re-forms covariance from a propagated square-root factor.
- Uses one time-multiplexed multiply-accumulate sequenced by an FSM: 35 product terms, one per enabled cycle.

---
 rtl/chol_pkg.sv | 17 +
 rtl/chol_mac.sv | 54 +++++
 rtl/cholesky_recon.sv | 139 +++++++++++++
 tb/tb_cholesky_recon.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/chol_pkg.sv
// Shared constants, triangular indexing and FSM state for the Cholesky factoriser/reconstructor pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chol_pkg;
    localparam int N         = 5;
    localparam int W         = 32;
    localparam int FRAC_BITS = 16;
    localparam int NUM_ELEMS = 15;
    localparam int ACC_W     = 2 * W;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    // Packed lower-triangle position of (i,j), 0-based, i >= j.
    function automatic logic [3:0] tri_idx(input int unsigned i, input int unsigned j);
        return 4'((i * (i + 1)) / 2 + j);
    endfunction
endpackage

// File: rtl/chol_mac.sv
// Signed WxW multiply into a 64-bit accumulator; emits the Q-shifted, W-bit element on the closing term.
// Latency: result is combinational on the last term; accumulator restarts on the following edge.
// Backpressure: none, all state freezes while clk_en_i is low. Saturation with CHOL_RECON_SAT_EN.
module chol_mac
    import chol_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clk_en_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         last_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] res_o,
    output logic         ovf_o
);
    logic signed [ACC_W-1:0] acc_q, acc_d, prod, sum;

    always_comb begin
        prod  = $signed({{W{a_i[W-1]}}, a_i} * {{W{b_i[W-1]}}, b_i});
        sum   = acc_q + prod;
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (en_i)
            acc_d = last_i ? '0 : sum;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            acc_q <= '0;
        else if (clk_en_i)
            acc_q <= acc_d;
    end

`ifdef CHOL_RECON_SAT_EN
    logic signed [ACC_W-1:0] shifted;

    // In range only when every bit from W-1 upward equals the sign.
    always_comb begin
        shifted = sum >>> FRAC_BITS;
        ovf_o   = !((&shifted[ACC_W-1:W-1]) || !(|shifted[ACC_W-1:W-1]));
        res_o   = shifted[W-1:0];
        if (ovf_o)
            res_o = shifted[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`else
    always_comb begin
        res_o = W'(sum >>> FRAC_BITS);
        ovf_o = 1'b0;
    end
`endif
endmodule

// File: rtl/cholesky_recon.sv
// Rebuilds A = L*L^T (lower triangle, Q16.16) from a packed 5x5 factor; saturating build via CHOL_RECON_SAT_EN.
// Latency: 36 enabled cycles from accept to A_valid; one matrix per 37 enabled cycles back to back.
// Backpressure: L_ready only in IDLE; clk_en low freezes everything, including a pending A_valid.
module cholesky_recon
    import chol_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic [NUM_ELEMS*W-1:0] L,
    input  logic                   L_valid,
    output logic                   L_ready,
    output logic [NUM_ELEMS*W-1:0] A,
    output logic                   A_valid,
    output logic                   ovf
);
    localparam logic [2:0] IMAX = 3'(N - 1);

    state_t      state_q, state_d;
    logic [2:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic        ovf_q, ovf_d, a_valid_q, a_valid_d;
    logic [W-1:0] l_q      [NUM_ELEMS];
    logic [W-1:0] shadow_q [NUM_ELEMS];
    logic [W-1:0] a_q      [NUM_ELEMS];

    logic         accept, mac_en, elem_last, last_term, elem_ovf;
    logic [W-1:0] op_a, op_b, mac_res;

    assign elem_last = (k_q == j_q);
    assign last_term = (i_q == IMAX) && (j_q == IMAX) && (k_q == IMAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else if (clk_en)
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (L_valid) state_d = MAC;
            MAC:     if (last_term) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        L_ready = (state_q == IDLE);
        accept  = (state_q == IDLE) && L_valid;
        mac_en  = (state_q == MAC);
    end

    // Term k of element (i,j) multiplies L_ik by L_jk.
    always_comb begin
        op_a = l_q[tri_idx(32'(i_q), 32'(k_q))];
        op_b = l_q[tri_idx(32'(j_q), 32'(k_q))];
    end

    chol_mac u_mac (
        .clk_i    (clk),
        .rst_n_i  (rst),
        .clk_en_i (clk_en),
        .en_i     (mac_en),
        .clr_i    (accept),
        .last_i   (elem_last),
        .a_i      (op_a),
        .b_i      (op_b),
        .res_o    (mac_res),
        .ovf_o    (elem_ovf)
    );

    always_comb begin
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        ovf_d     = ovf_q;
        a_valid_d = (state_q == DONE);
        if (accept) begin
            i_d   = '0;
            j_d   = '0;
            k_d   = '0;
            ovf_d = 1'b0;
        end else if (mac_en) begin
            if (elem_last) begin
                k_d   = '0;
                ovf_d = ovf_q | elem_ovf;
                if (last_term) begin
                    i_d = '0;
                    j_d = '0;
                end else if (j_q == i_q) begin
                    j_d = '0;
                    i_d = i_q + 3'd1;
                end else begin
                    j_d = j_q + 3'd1;
                end
            end else begin
                k_d = k_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            ovf_q     <= 1'b0;
            a_valid_q <= 1'b0;
            for (int e = 0; e < NUM_ELEMS; e++) begin
                l_q[e]      <= '0;
                shadow_q[e] <= '0;
                a_q[e]      <= '0;
            end
        end else if (clk_en) begin
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            ovf_q     <= ovf_d;
            a_valid_q <= a_valid_d;
            if (accept)
                for (int e = 0; e < NUM_ELEMS; e++)
                    l_q[e] <= L[e*W +: W];
            if (mac_en && elem_last)
                shadow_q[tri_idx(32'(i_q), 32'(j_q))] <= mac_res;
            if (state_q == DONE)
                a_q <= shadow_q;
        end
    end

    always_comb begin
        for (int e = 0; e < NUM_ELEMS; e++)
            A[e*W +: W] = a_q[e];
    end

    assign A_valid = a_valid_q;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_cholesky_recon.sv
// Directed bench for cholesky_recon: reset, identity/mixed/negative/overflow, handshake, stall, abort, back-to-back.
module tb_cholesky_recon;
    import chol_pkg::*;

    localparam int PW = NUM_ELEMS * W;
    localparam logic [31:0] ONE = 32'h0001_0000;

    logic          clk = 1'b0;
    logic          rst, clk_en, L_valid, L_ready, A_valid, ovf;
    logic [PW-1:0] L, A;

    int n_chk  = 0;
    int n_pass = 0;

    logic [PW-1:0] v_ident, v_mixed, e_mixed, v_neg, e_neg, v_ovf, e_ovf;

    always #5 clk = ~clk;

    cholesky_recon dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .L       (L),
        .L_valid (L_valid),
        .L_ready (L_ready),
        .A       (A),
        .A_valid (A_valid),
        .ovf     (ovf)
    );

    // Accepts lv, then counts every posedge (stalled ones too) up to the A_valid edge.
    task automatic run(input logic [PW-1:0] lv, input logic [PW-1:0] alt,
                       input int stall_at, input int stall_len, input int pulse_at,
                       output int edges, output logic [PW-1:0] a_got,
                       output logic ovf_got, output logic rdy_got);
        int tot;
        tot     = 0;
        edges   = -1;
        a_got   = '0;
        ovf_got = 1'b0;
        rdy_got = 1'b0;
        L       = lv;
        L_valid = 1'b1;
        @(posedge clk); #1;
        L_valid = 1'b0;
        L       = '0;
        for (int c = 1; c <= 200; c++) begin
            if (c == stall_at) begin
                clk_en = 1'b0;
                repeat (stall_len) @(posedge clk);
                tot += stall_len;
                #1;
                clk_en = 1'b1;
            end
            if (c == pulse_at) begin
                L       = alt;
                L_valid = 1'b1;
            end
            @(posedge clk); #1;
            tot++;
            L_valid = 1'b0;
            if (A_valid) begin
                edges   = tot;
                a_got   = A;
                ovf_got = ovf;
                rdy_got = L_ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; clk_en = 1'b1; L_valid = 1'b0; L = '0;
        repeat (2) @(posedge clk); #1;
        n_chk++; if (A !== '0) $display("FAIL reset_A got %h expected 0", A); else n_pass++;
        n_chk++; if (A_valid !== 1'b0) $display("FAIL reset_A_valid got %b expected 0", A_valid); else n_pass++;
        n_chk++; if (L_ready !== 1'b1) $display("FAIL reset_L_ready got %b expected 1", L_ready); else n_pass++;
        n_chk++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b expected 0", ovf); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        int ed; logic [PW-1:0] ag; logic og, rg;
        run(v_ident, '0, 0, 0, 0, ed, ag, og, rg);
        n_chk++; if (ed !== 36) $display("FAIL ident_latency got %0d expected 36", ed); else n_pass++;
        n_chk++; if (ag !== v_ident) $display("FAIL ident_A got %h expected %h", ag, v_ident); else n_pass++;
        n_chk++; if (og !== 1'b0) $display("FAIL ident_ovf got %b expected 0", og); else n_pass++;
        n_chk++; if (rg !== 1'b1) $display("FAIL ident_ready_with_valid got %b expected 1", rg); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (A_valid !== 1'b0) $display("FAIL ident_valid_pulse got %b expected 0", A_valid); else n_pass++;
        n_chk++; if (A !== v_ident) $display("FAIL ident_A_held got %h expected %h", A, v_ident); else n_pass++;
    endtask

    task automatic test_mixed();
        int ed; logic [PW-1:0] ag; logic og, rg;
        run(v_mixed, '0, 0, 0, 0, ed, ag, og, rg);
        n_chk++; if (ed !== 36) $display("FAIL mixed_latency got %0d expected 36", ed); else n_pass++;
        n_chk++; if (ag !== e_mixed) $display("FAIL mixed_A got %h expected %h", ag, e_mixed); else n_pass++;
    endtask

    task automatic test_negative();
        int ed; logic [PW-1:0] ag; logic og, rg;
        run(v_neg, '0, 0, 0, 0, ed, ag, og, rg);
        n_chk++; if (ag !== e_neg) $display("FAIL neg_A got %h expected %h", ag, e_neg); else n_pass++;
    endtask

    task automatic test_overflow();
        int ed; logic [PW-1:0] ag; logic og, rg; logic exp_ovf;
`ifdef CHOL_RECON_SAT_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        run(v_ovf, '0, 0, 0, 0, ed, ag, og, rg);
        n_chk++; if (ag !== e_ovf) $display("FAIL ovf_A got %h expected %h", ag, e_ovf); else n_pass++;
        n_chk++; if (og !== exp_ovf) $display("FAIL ovf_flag got %b expected %b", og, exp_ovf); else n_pass++;
        run(v_ident, '0, 0, 0, 0, ed, ag, og, rg);
        n_chk++; if (og !== 1'b0) $display("FAIL ovf_clears_on_accept got %b expected 0", og); else n_pass++;
    endtask

    task automatic test_handshake();
        int ed; logic [PW-1:0] ag; logic og, rg;
        run(v_ident, v_ovf, 0, 0, 5, ed, ag, og, rg);
        n_chk++; if (ed !== 36) $display("FAIL hs_latency got %0d expected 36", ed); else n_pass++;
        n_chk++; if (ag !== v_ident) $display("FAIL hs_A got %h expected %h", ag, v_ident); else n_pass++;
    endtask

    task automatic test_stall();
        int ed; logic [PW-1:0] ag; logic og, rg;
        run(v_mixed, '0, 12, 7, 0, ed, ag, og, rg);
        n_chk++; if (ed !== 43) $display("FAIL stall_latency got %0d expected 43", ed); else n_pass++;
        n_chk++; if (ag !== e_mixed) $display("FAIL stall_A got %h expected %h", ag, e_mixed); else n_pass++;
        // A_valid must survive a disabled edge.
        clk_en = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (A_valid !== 1'b1) $display("FAIL stall_valid_hold got %b expected 1", A_valid); else n_pass++;
        clk_en = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (A_valid !== 1'b0) $display("FAIL stall_valid_drop got %b expected 0", A_valid); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int ed, pulses; logic [PW-1:0] ag; logic og, rg;
        L = v_mixed; L_valid = 1'b1;
        @(posedge clk); #1;
        L_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        n_chk++; if (A !== '0) $display("FAIL abort_A got %h expected 0", A); else n_pass++;
        n_chk++; if (L_ready !== 1'b1) $display("FAIL abort_L_ready got %b expected 1", L_ready); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (A_valid) pulses++;
        end
        n_chk++; if (pulses !== 0) $display("FAIL abort_no_valid got %0d expected 0", pulses); else n_pass++;
        n_chk++; if (A !== '0) $display("FAIL abort_A_after got %h expected 0", A); else n_pass++;
        run(v_ident, '0, 0, 0, 0, ed, ag, og, rg);
        n_chk++; if (ed !== 36) $display("FAIL abort_rerun_latency got %0d expected 36", ed); else n_pass++;
        n_chk++; if (ag !== v_ident) $display("FAIL abort_rerun_A got %h expected %h", ag, v_ident); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ed, tot; logic [PW-1:0] ag; logic og, rg;
        run(v_mixed, '0, 0, 0, 0, ed, ag, og, rg);
        // Hold L_valid into the A_valid cycle so the next matrix is taken on the following edge.
        L = v_neg; L_valid = 1'b1;
        @(posedge clk); #1;
        L_valid = 1'b0;
        n_chk++; if (L_ready !== 1'b0) $display("FAIL b2b_accept got %b expected 0", L_ready); else n_pass++;
        tot = -1;
        for (int c = 2; c <= 200; c++) begin
            @(posedge clk); #1;
            if (A_valid) begin tot = c; break; end
        end
        n_chk++; if (tot !== 37) $display("FAIL b2b_interval got %0d expected 37", tot); else n_pass++;
        n_chk++; if (A !== e_neg) $display("FAIL b2b_A got %h expected %h", A, e_neg); else n_pass++;
    endtask

    initial begin
        v_ident = '0;
        v_ident[0*32 +: 32] = ONE;  v_ident[2*32 +: 32] = ONE;  v_ident[5*32 +: 32] = ONE;
        v_ident[9*32 +: 32] = ONE;  v_ident[14*32 +: 32] = ONE;

        v_mixed = v_ident;
        v_mixed[0*32 +: 32] = 32'h0005_0000;
        v_mixed[1*32 +: 32] = 32'h0003_0000;
        v_mixed[2*32 +: 32] = 32'h0004_0000;
        e_mixed = v_ident;
        e_mixed[0*32 +: 32] = 32'h0019_0000;
        e_mixed[1*32 +: 32] = 32'h000F_0000;
        e_mixed[2*32 +: 32] = 32'h0019_0000;

        v_neg = v_ident;
        v_neg[1*32 +: 32] = 32'hFFFF_0000;
        e_neg = v_ident;
        e_neg[1*32 +: 32] = 32'hFFFF_0000;
        e_neg[2*32 +: 32] = 32'h0002_0000;

        v_ovf = v_ident;
        v_ovf[0*32 +: 32] = 32'h0100_0000;
        e_ovf = v_ident;
`ifdef CHOL_RECON_SAT_EN
        e_ovf[0*32 +: 32] = 32'h7FFF_FFFF;
`else
        e_ovf[0*32 +: 32] = 32'h0000_0000;
`endif

        test_reset();
        test_identity();
        test_mixed();
        test_negative();
        test_overflow();
        test_handshake();
        test_stall();
        test_reset_abort();
        test_back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule
